// File: rtl/coin_pkg.sv
// Shared money codes, output FSM states and coin values for the coin acceptor.
package coin_pkg;

  localparam logic [1:0] MONEY_NONE = 2'b00;
  localparam logic [1:0] MONEY_25   = 2'b01;
  localparam logic [1:0] MONEY_50   = 2'b10;

  localparam logic [7:0] PAISE_25 = 8'd25;
  localparam logic [7:0] PAISE_50 = 8'd50;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    GAP
  } out_state_t;

  function automatic logic [7:0] coin_paise(input logic [1:0] code);
    return (code == MONEY_50) ? PAISE_50 : PAISE_25;
  endfunction

  // Saturating 8-bit add: the running total parks at 255 instead of wrapping.
  function automatic logic [7:0] add_sat(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge strobe for one coin sensor.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          settle;

  // The strobe fires in the cycle the new level is committed, so a coin is
  // pushed on the same edge the debounced level rises.
  assign settle = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = settle && sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (settle) begin
        cnt    <= '0;
        stable <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounced sensors feed a small coin queue that is emitted one
// spaced coin at a time. Define COIN_TOTAL_EN to add the saturating total_paise output.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin25_raw,
  input  logic                          coin50_raw,
  input  logic                          accept_en,
  output logic [1:0]                    money,
  output logic                          reject,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef COIN_TOTAL_EN
  ,
  output logic [7:0]                    total_paise
`endif
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int GW   = $clog2(GAP_CYCLES + 1);

  logic ev25;
  logic ev50;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db25 (
    .clk  (clk),
    .rst  (rst),
    .raw  (coin25_raw),
    .rise (ev25)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db50 (
    .clk  (clk),
    .rst  (rst),
    .raw  (coin50_raw),
    .rise (ev50)
  );

  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  out_state_t    state;
  logic [GW-1:0] gap_cnt;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic [1:0]    push_code;

  assign full      = (fifo_count == CNTW'(FIFO_DEPTH));
  assign push_req  = ev25 ^ ev50;
  assign push_code = ev50 ? MONEY_50 : MONEY_25;
  assign pop       = (state == IDLE) && accept_en && (fifo_count != '0);
  // A pop in the same cycle frees the head slot, so a full queue can still take a coin.
  assign push      = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      reject     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
      reject <= (ev25 && ev50) || (push_req && !push);
    end
  end

  // Output sequencer: one coin cycle, then GAP_CYCLES+1 idle cycles minimum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      money   <= MONEY_NONE;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            money <= mem[rd_ptr];
            state <= EMIT;
          end
        end
        EMIT: begin
          money   <= MONEY_NONE;
          gap_cnt <= GW'(GAP_CYCLES);
          state   <= GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt <= GW'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          money <= MONEY_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef COIN_TOTAL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_paise <= 8'd0;
    end else if (money != MONEY_NONE) begin
      total_paise <= add_sat(total_paise, coin_paise(money));
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus predicts coins/rejects, a negedge monitor checks them.
module tb_coin_acceptor;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin25_raw = 1'b0;
  logic       coin50_raw = 1'b0;
  logic       accept_en = 1'b0;
  logic [1:0] money;
  logic       reject;
  logic [2:0] fifo_count;
`ifdef COIN_TOTAL_EN
  logic [7:0] total_paise;
`endif

  coin_acceptor #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (DEPTH),
    .GAP_CYCLES      (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin25_raw (coin25_raw),
    .coin50_raw (coin50_raw),
    .accept_en  (accept_en),
    .money      (money),
    .reject     (reject),
    .fifo_count (fifo_count)
`ifdef COIN_TOTAL_EN
    ,
    .total_paise(total_paise)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_rej = 0;
  int rej_seen = 0;
  int cyc = 0;
  int last_emit = -100;
`ifdef COIN_TOTAL_EN
  int exp_total = 0;
  bit total_pending = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: every non-zero money cycle consumes the next predicted coin.
  always @(negedge clk) begin
    int v;
    cyc++;
    if (!rst) begin
`ifdef COIN_TOTAL_EN
      if (total_pending) begin
        chk("total_paise", int'(total_paise), exp_total);
        total_pending = 1'b0;
      end
`endif
      if (reject) rej_seen++;
      if (money != 2'b00) begin
        chk("coin spacing >= 3 cycles", int'((cyc - last_emit) >= 3), 1);
        last_emit = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected coin code", int'(money), 0);
        end else begin
          v = exp_q.pop_front();
          chk("money code", int'(money), (v == 25) ? 1 : 2);
`ifdef COIN_TOTAL_EN
          exp_total = (exp_total + v > 255) ? 255 : exp_total + v;
          total_pending = 1'b1;
`endif
        end
      end
    end
  end

  task automatic set_raw(input int kind, input logic v);
    if (kind != 1) coin25_raw = v;
    if (kind != 0) coin50_raw = v;
  endtask

  // kind: 0 = 25p, 1 = 50p, 2 = both sensors together
  task automatic drive_coin(input int kind, input bit bounce);
    @(negedge clk);
    if (bounce) begin
      for (int i = 0; i < 4; i++) begin
        set_raw(kind, ~i[0]);
        @(negedge clk);
      end
    end
    set_raw(kind, 1'b1);
    repeat (10) @(negedge clk);
    set_raw(kind, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  // Reference rule: a single coin is queued if room remains, otherwise returned.
  task automatic insert(input int kind, input bit bounce);
    if (kind == 2) exp_rej++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(kind == 0 ? 25 : 50);
    else exp_rej++;
    drive_coin(kind, bounce);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({name, " drain timeout, coins left"}, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
    chk({name, " fifo_count"}, int'(fifo_count), 0);
    chk({name, " reject count"}, rej_seen, exp_rej);
  endtask

  initial begin
    int lat;
    int n;
    int mode;
    bit found;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset money", int'(money), 0);
    chk("reset reject", int'(reject), 0);
    chk("reset fifo_count", int'(fifo_count), 0);
`ifdef COIN_TOTAL_EN
    chk("reset total_paise", int'(total_paise), 0);
`endif
    rst = 1'b0;

    // Clean 25p coin: money appears 2+4+1 edges after the raw rise
    accept_en = 1'b1;
    exp_q.push_back(25);
    @(negedge clk);
    coin25_raw = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (money != 2'b00) lat = i;
    end
    chk("coin25 latency", lat, 7);
    repeat (5) @(negedge clk);
    coin25_raw = 1'b0;
    repeat (10) @(negedge clk);
    drain("single25");

    insert(1, 1'b1);
    drain("bounce50");

    // Burst into a held queue: fifth coin is returned
    accept_en = 1'b0;
    insert(0, 1'b0); insert(1, 1'b0); insert(0, 1'b0); insert(1, 1'b0); insert(0, 1'b0);
    chk("burst fifo_count", int'(fifo_count), 4);
    chk("burst reject count", rej_seen, exp_rej);
    accept_en = 1'b1;
    drain("burst");

    insert(2, 1'b0);
    drain("both sensors");

    // Full queue where the new push lands on the same edge as the first pop
    accept_en = 1'b0;
    insert(0, 1'b0); insert(1, 1'b0); insert(1, 1'b0); insert(0, 1'b0);
    chk("prefull fifo_count", int'(fifo_count), 4);
    exp_q.push_back(25);
    @(negedge clk);
    coin25_raw = 1'b1;
    repeat (5) @(negedge clk);
    accept_en = 1'b1;
    @(negedge clk);
    chk("push+pop on full fifo_count", int'(fifo_count), 4);
    chk("push+pop on full reject count", rej_seen, exp_rej);
    repeat (5) @(negedge clk);
    coin25_raw = 1'b0;
    repeat (10) @(negedge clk);
    drain("full push+pop");

    // Async reset while a 50p coin is on the money bus
    accept_en = 1'b0;
    insert(0, 1'b0); insert(1, 1'b0); insert(0, 1'b0); insert(0, 1'b0);
    accept_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (money == 2'b10) found = 1'b1;
    end
    chk("money=50 seen before reset", int'(found), 1);
    #1 rst = 1'b1;
    #1;
    chk("async reset money", int'(money), 0);
    chk("async reset fifo_count", int'(fifo_count), 0);
`ifdef COIN_TOTAL_EN
    chk("async reset total_paise", int'(total_paise), 0);
    exp_total = 0;
    total_pending = 1'b0;
`endif
    exp_q.delete();
    @(negedge clk);
    chk("reject during reset", int'(reject), 0);
    rst = 1'b0;

    // Eleven 25p coins: 275 paise saturates at 255
    for (int i = 0; i < 11; i++) insert(0, 1'(($urandom_range(0, 1))));
    drain("saturation run");
`ifdef COIN_TOTAL_EN
    chk("saturated total_paise", int'(total_paise), 255);
`endif

    // Randomised rounds
    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        accept_en = 1'b1;
        insert($urandom_range(0, 1), 1'($urandom_range(0, 1)));
        drain("rand single");
      end else if (mode == 1) begin
        accept_en = 1'b0;
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) insert($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        chk("rand burst fifo_count", int'(fifo_count), exp_q.size());
        accept_en = 1'b1;
        drain("rand burst");
      end else begin
        accept_en = 1'b1;
        insert(2, 1'b0);
        drain("rand both");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Upstream front end of the single-product vending FSM. Synchronises and debounces the raw 25p and 50p coin-sensor lines, and queues validated coins in a small FIFO. Presents coins one at a time on the 2-bit money code the vending FSM samples every clock: 00 none, 01 = 25p, 10 = 50p. Spaces coins so the FSM never sees two back-to-back non-zero codes, and returns (rejects) coins it cannot accept.

Parameters:
DEBOUNCE_CYCLES, 4, cycles a synchronised sensor line must stay stable before its level is accepted (>=1)
FIFO_DEPTH, 4, coin queue entries (power of 2, >=2)
GAP_CYCLES, 1, minimum number of money=00 cycles inserted after each emitted coin (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
coin25_raw  input  1  raw 25p sensor, asynchronous to clk, may bounce
coin50_raw  input  1  raw 50p sensor, asynchronous to clk, may bounce
accept_en  input  1  1 = emit queued coins; 0 = hold the queue (coins still captured)
money  output  2  coin code to the vending FSM, registered, non-zero for exactly one cycle per coin
reject  output  1  one-cycle pulse: coin returned to customer (queue full or both sensors fired)
fifo_count  output  clog2(FIFO_DEPTH)+1  number of queued coins

Behaviour:
- Reset (async assert, release synchronous to clk): money=00, reject=0, fifo_count=0, synchronisers=0, debounced levels=0, counters=0, FSM=IDLE.
- Input path per sensor: 2-flop synchroniser -> debounce counter. The counter resets whenever the synchronised input differs from the debounced level. When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the new value.
- Coin event: a rising edge of a debounced level, one cycle wide. Latency from a stable raw high to the event = 2 + DEBOUNCE_CYCLES cycles.
- Event resolution, same cycle:
  - only ev25 -> push code 01
  - only ev50 -> push code 10
  - both -> no push, reject=1
  - push while fifo_count==FIFO_DEPTH -> dropped, reject=1
- FIFO: synchronous, circular read/write pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop leaves the count unchanged; this is legal even when the queue is full, because the pop frees the slot before the push in the same cycle.
- Output FSM:
  - IDLE: if accept_en && fifo_count>0 -> pop; money <= head code (next cycle); go EMIT.
  - EMIT, one cycle: money <= 00; load the gap counter with GAP_CYCLES; go GAP.
  - GAP: decrement the counter; at 0 -> IDLE. money stays 00.
- Money timing: money is non-zero for exactly 1 cycle. With GAP_CYCLES=1, coins are spaced at least 3 cycles apart.
- accept_en deasserted mid-EMIT or mid-GAP: the current coin completes and no new pop occurs.
- Reset mid-operation: queued coins are discarded, money returns to 00 immediately (async), and no reject is generated.

Optional Feature:
Macro COIN_TOTAL_EN.
- Defined: adds output total_paise [7:0]. Incremented by 25 or 50 on the cycle money is non-zero. Saturates at 255 and never wraps. Cleared by rst.
- Not defined: no port, no counter; all other behaviour is identical.

Decomposition:
- Package coin_pkg:
  - money code constants MONEY_NONE=2'b00, MONEY_25=2'b01, MONEY_50=2'b10
  - output FSM state enum (IDLE, EMIT, GAP)
  - paise value constants 25/50
- Sub-module coin_debounce (synchroniser + debounce counter + rising-edge detect, parameter DEBOUNCE_CYCLES). Instantiated twice, once per sensor. The FIFO stays inline.

Test Plan:
- Reset, then a clean coin25_raw pulse held 10 cycles, DEBOUNCE_CYCLES=4, accept_en=1 -> money=01 for exactly one cycle, 2+4+1 cycles after the raw rise; then 00; fifo_count returns to 0.
- coin50_raw bouncing 0/1 every cycle for 3 cycles, then high for 8 -> exactly one money=10 pulse, no reject.
- accept_en=0; insert 5 coins (25,50,25,50,25), DEPTH=4 -> fifo_count=4, one reject pulse on the 5th. Then accept_en=1 -> money sequence 01,10,01,10, each separated by at least 2 cycles of 00.
- Both sensors debounce-rise in the same cycle -> reject=1 for one cycle, no push, money stays 00.
- Full queue with accept_en=1: push coincides with pop -> no reject, fifo_count stays 4.
- Assert rst asynchronously while money=10 -> money=00 before the next clk edge, fifo_count=0. With COIN_TOTAL_EN, total_paise=0. After release, 11 queued 25p coins drive total_paise to 255 and hold it there (saturated).
